// File: rtl/vga_conv_window.sv
// vga_conv_window: builds a registered 3x3 pixel window from the live pixel
// stream plus two line RAMs holding the previous two active lines.
// window_valid is raised only where a full neighbourhood exists (no border).
// Optional build macro VGA_CONV_WINDOW_STATS_EN adds the frame_windows port,
// which reports the number of valid windows produced in the previous frame.
module vga_conv_window #(
   parameter int DATA_W = 8,
   parameter int LINE_W = 640,
   parameter int X_W    = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pixel_tick,
   input  logic                hvideo_on,
   input  logic [X_W-1:0]      x_pos,
   input  logic                eol,
   input  logic                sof,
   input  logic [DATA_W-1:0]   pixel_in,
   output logic [9*DATA_W-1:0] window,
   output logic                window_valid,
   output logic [X_W-1:0]      win_x
`ifdef VGA_CONV_WINDOW_STATS_EN
   ,
   output logic [19:0]         frame_windows
`endif
);

   localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [X_W:0] LINE_W_EXT = (X_W+1)'(LINE_W);

   // A column is packed as [0]=top (oldest row), [1]=mid, [2]=current row.
   typedef logic [2:0][DATA_W-1:0] column_t;

   logic              accept;
   logic [AW-1:0]     addr;
   logic [DATA_W-1:0] top_pix;
   logic [DATA_W-1:0] mid_pix;

   logic [DATA_W-1:0] lb0_mem [0:LINE_W-1];
   logic [DATA_W-1:0] lb1_mem [0:LINE_W-1];

   // Two stored columns; the third (rightmost) column is the one being built.
   column_t col_reg [0:1];
   column_t win_col [0:2];

   logic [9*DATA_W-1:0] window_next;
   logic                valid_next;
   logic [1:0]          col_cnt_reg, col_cnt_next;
   logic [1:0]          rows_filled_reg, rows_filled_next;
   logic                line_acc_reg, line_acc_next;

   assign accept  = pixel_tick && hvideo_on && ({1'b0, x_pos} < LINE_W_EXT);
   assign addr    = AW'(x_pos);

   // Combinational read so the window sees the stored rows in the same tick.
   assign top_pix = lb1_mem[addr];
   assign mid_pix = lb0_mem[addr];

   assign win_col[0] = col_reg[0];
   assign win_col[1] = col_reg[1];
   assign win_col[2] = {pixel_in, mid_pix, top_pix};

   // Window element r*3+c comes from column c, row r.
   genvar gi, gj;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_col
         for (gj = 0; gj < 3; gj++) begin : g_row
            assign window_next[(gj*3+gi)*DATA_W +: DATA_W] = win_col[gi][gj];
         end
      end
   endgenerate

   // Full neighbourhood: two buffered lines and two earlier columns this line.
   assign valid_next = accept && (rows_filled_reg == 2'd2) && (col_cnt_reg >= 2'd2);

   // Line RAM update: each line shifts down one RAM (read-before-write).
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_mem[addr] <= pixel_in;
         lb1_mem[addr] <= lb0_mem[addr];
      end
   end

   // Next-state for column/row fill tracking; sof overrides eol.
   always_comb begin
      col_cnt_next     = col_cnt_reg;
      rows_filled_next = rows_filled_reg;
      line_acc_next    = line_acc_reg;
      if (pixel_tick) begin
         if (accept) begin
            col_cnt_next  = (col_cnt_reg == 2'd3) ? 2'd3 : col_cnt_reg + 2'd1;
            line_acc_next = 1'b1;
         end
         if (sof) begin
            rows_filled_next = 2'd0;
            col_cnt_next     = 2'd0;
            line_acc_next    = 1'b0;
         end else if (eol) begin
            if (line_acc_reg || accept) begin
               rows_filled_next = (rows_filled_reg == 2'd2) ? 2'd2 : rows_filled_reg + 2'd1;
            end
            col_cnt_next  = 2'd0;
            line_acc_next = 1'b0;
         end
      end
   end

   // Fill counters, column shift registers and registered window outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_cnt_reg     <= 2'd0;
         rows_filled_reg <= 2'd0;
         line_acc_reg    <= 1'b0;
         col_reg[0]      <= '0;
         col_reg[1]      <= '0;
         window          <= '0;
         window_valid    <= 1'b0;
         win_x           <= '0;
      end else begin
         col_cnt_reg     <= col_cnt_next;
         rows_filled_reg <= rows_filled_next;
         line_acc_reg    <= line_acc_next;
         if (accept) begin
            col_reg[0] <= col_reg[1];
            col_reg[1] <= win_col[2];
         end
         if (pixel_tick) begin
            window_valid <= valid_next;
            if (valid_next) begin
               window <= window_next;
               win_x  <= x_pos - X_W'(1);
            end
         end
      end
   end

`ifdef VGA_CONV_WINDOW_STATS_EN
   logic [19:0] win_cnt_reg;

   // Per-frame window counter, snapshotted into frame_windows on sof.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_cnt_reg   <= 20'd0;
         frame_windows <= 20'd0;
      end else if (pixel_tick) begin
         if (sof) begin
            frame_windows <= win_cnt_reg;
            win_cnt_reg   <= 20'd0;
         end else if (valid_next && (win_cnt_reg != 20'hFFFFF)) begin
            win_cnt_reg <= win_cnt_reg + 20'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_conv_window.sv
// tb_vga_conv_window: directed scenarios plus randomized frames, checked
// against a line-history reference model of the 3x3 window rules.
`timescale 1ns/1ps
module tb_vga_conv_window;

   localparam int DW = 8;
   localparam int LW = 8;
   localparam int XW = 4;

   localparam logic [7:0] S1 [9] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

   logic          clk = 1'b0;
   logic          reset;
   logic          pixel_tick;
   logic          hvideo_on;
   logic [XW-1:0] x_pos;
   logic          eol;
   logic          sof;
   logic [DW-1:0] pixel_in;
   logic [9*DW-1:0] window;
   logic          window_valid;
   logic [XW-1:0] win_x;
`ifdef VGA_CONV_WINDOW_STATS_EN
   logic [19:0]   frame_windows;
`endif

   vga_conv_window #(.DATA_W(DW), .LINE_W(LW), .X_W(XW)) dut (
      .clk          (clk),
      .reset        (reset),
      .pixel_tick   (pixel_tick),
      .hvideo_on    (hvideo_on),
      .x_pos        (x_pos),
      .eol          (eol),
      .sof          (sof),
      .pixel_in     (pixel_in),
      .window       (window),
      .window_valid (window_valid),
      .win_x        (win_x)
`ifdef VGA_CONV_WINDOW_STATS_EN
      ,
      .frame_windows(frame_windows)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int         tag;
      int         wx;
      int         idx;
      logic [7:0] exp;
   } vec_t;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: completed-line images and the current line.
   int          m_filled;
   bit          m_line_acc;
   logic [7:0]  hist1 [LW];
   logic [7:0]  hist2 [LW];
   logic [7:0]  cur   [LW];
   int          q_x [$];
   logic        e_valid;
   logic [71:0] e_window;
   logic [3:0]  e_winx;
   int          m_cnt;
   logic [19:0] e_fw;

   int          gap = 0;
   bit          rnd_gap = 0;
   int          tag = -1;
   logic [71:0] snap [3][LW];
   int          line_valid;
   int          first_wx;
   int          last_wx;

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_filled   = 0;
      m_line_acc = 0;
      q_x.delete();
      e_valid    = 1'b0;
      e_window   = '0;
      e_winx     = '0;
      m_cnt      = 0;
      e_fw       = '0;
   endtask

   // Applies one pixel_tick worth of the window rules.
   task automatic model_step(input int hv, input int x, input int e, input int s, input int p);
      bit acc;
      bit v;
      int xc;
      acc = (hv != 0) && (x < LW);
      e_valid = 1'b0;
      if (acc) begin
         v = (m_filled >= 2) && (q_x.size() >= 2);
         cur[x] = 8'(p);
         q_x.push_back(x);
         if (q_x.size() > 3) void'(q_x.pop_front());
         e_valid = v;
         if (v) begin
            for (int c = 0; c < 3; c++) begin
               xc = q_x[c];
               e_window[c*8 +: 8]     = hist2[xc];
               e_window[(3+c)*8 +: 8] = hist1[xc];
               e_window[(6+c)*8 +: 8] = cur[xc];
            end
            e_winx = 4'(x - 1);
         end
      end
      if (s != 0) begin
         e_fw  = 20'(m_cnt);
         m_cnt = 0;
      end else if (e_valid && m_cnt < 20'hFFFFF) begin
         m_cnt++;
      end
      if ((s != 0) || (e != 0)) begin
         if (m_line_acc || acc) begin
            hist2 = hist1;
            hist1 = cur;
            if (s == 0 && m_filled < 2) m_filled++;
         end
         if (s != 0) m_filled = 0;
         m_line_acc = 0;
         q_x.delete();
      end else if (acc) begin
         m_line_acc = 1;
      end
   endtask

   task automatic do_cycle(input int t, input int hv, input int x, input int e, input int s, input int p);
      pixel_tick = (t != 0);
      hvideo_on  = (hv != 0);
      x_pos      = 4'(x);
      eol        = (e != 0);
      sof        = (s != 0);
      pixel_in   = 8'(p);
      @(posedge clk);
      #1;
      if (t != 0) begin
         model_step(hv, x, e, s, p);
         if (window_valid) begin
            line_valid++;
            if (first_wx < 0) first_wx = int'(win_x);
            last_wx = int'(win_x);
            if (tag >= 0) snap[tag][win_x[2:0]] = window;
         end
      end
      check("window_valid", 72'(window_valid), 72'(e_valid));
      check("win_x", 72'(win_x), 72'(e_winx));
      check("window", window, e_window);
`ifdef VGA_CONV_WINDOW_STATS_EN
      check("frame_windows", 72'(frame_windows), 72'(e_fw));
`endif
   endtask

   task automatic drive_tick(input int hv, input int x, input int e, input int s, input int p);
      int idle;
      idle = rnd_gap ? int'($urandom_range(0, 2)) : gap;
      for (int i = 0; i < idle; i++) do_cycle(0, hv, x, e, s, int'($urandom_range(0, 255)));
      do_cycle(1, hv, x, e, s, p);
   endtask

   task automatic drive_sof();
      drive_tick(0, 0, 0, 1, 0);
      drive_tick(0, 0, 0, 0, 0);
   endtask

   task automatic drive_line(input int row, input bit inject, input bit rnd, input bit end_sof);
      line_valid = 0;
      first_wx   = -1;
      last_wx    = -1;
      for (int x = 0; x < LW; x++) begin
         if (inject && x == 4) begin
            drive_tick(1, 9, 0, 0, 8'hEE);
            check("xpos9_valid", 72'(window_valid), 72'(0));
         end
         if (rnd && $urandom_range(0, 5) == 0)
            drive_tick(0, int'($urandom_range(0, 15)), 0, 0, int'($urandom_range(0, 255)));
         if (rnd && $urandom_range(0, 7) == 0)
            drive_tick(1, int'($urandom_range(8, 15)), 0, 0, int'($urandom_range(0, 255)));
         drive_tick(1, x, 0, 0, rnd ? int'($urandom_range(0, 255)) : ((row % 16) * 16 + x));
      end
      drive_tick(0, 0, 1, end_sof ? 1 : 0, 0);
      drive_tick(0, 0, 0, 0, 0);
      $display("line row=%0d valid=%0d first_wx=%0d last_wx=%0d", row, line_valid, first_wx, last_wx);
   endtask

   task automatic expect_line(input string name, input int cnt);
      check({name, "_count"}, 72'(line_valid), 72'(cnt));
      if (cnt > 0) begin
         check({name, "_first"}, 72'(first_wx), 72'(1));
         check({name, "_last"}, 72'(last_wx), 72'(LW - 2));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [20];
      for (int i = 0; i < 9; i++) begin
         tbl[i]     = '{0, 1, i, S1[i]};
         tbl[9 + i] = '{2, 1, i, S1[i]};
      end
      tbl[18] = '{1, 6, 0, 8'h15};
      tbl[19] = '{1, 6, 8, 8'h37};
      for (int t = 0; t < 3; t++)
         for (int w = 0; w < LW; w++) snap[t][w] = '0;

      reset = 1'b1; pixel_tick = 1'b0; hvideo_on = 1'b0; x_pos = '0;
      eol = 1'b0; sof = 1'b0; pixel_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 72'(window_valid), 72'(0));
      check("rst_window", window, 72'(0));
      check("rst_win_x", 72'(win_x), 72'(0));
      reset = 1'b0;

      // Fresh frame: two fill lines, then full lines of windows.
      drive_sof();
      drive_line(0, 0, 0, 0); expect_line("s1_l0", 0);
      drive_line(1, 0, 0, 0); expect_line("s1_l1", 0);
      tag = 0;
      drive_line(2, 0, 0, 0); expect_line("s1_l2", 6);
      tag = 1;
      drive_line(3, 0, 0, 0); expect_line("s2_l3", 6);
      tag = -1;

      // Asynchronous reset in the middle of a line.
      for (int x = 0; x < 4; x++) drive_tick(1, x, 0, 0, 4 * 16 + x);
      pixel_tick = 1'b1; hvideo_on = 1'b1; x_pos = 4'd4; pixel_in = 8'h44;
      #2;
      reset = 1'b1;
      #1;
      check("arst_valid", 72'(window_valid), 72'(0));
      check("arst_window", window, 72'(0));
      check("arst_win_x", 72'(win_x), 72'(0));
      model_reset();
      pixel_tick = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      drive_line(5, 0, 0, 0); expect_line("s3_l5", 0);
      drive_line(6, 0, 0, 0); expect_line("s3_l6", 0);
      drive_line(7, 0, 0, 0); expect_line("s3_l7", 6);

      // sof coinciding with eol restarts the fill.
      drive_line(8, 0, 0, 1); expect_line("s4_l8", 6);
      drive_line(9, 0, 0, 0); expect_line("s4_l9", 0);
      drive_line(10, 0, 0, 0); expect_line("s4_l10", 0);
      drive_line(11, 0, 0, 0); expect_line("s4_l11", 6);

      // Quarter-rate pixel_tick with out-of-range x_pos injected.
      gap = 3;
      drive_sof();
      drive_line(0, 1, 0, 0); expect_line("s5_l0", 0);
      drive_line(1, 0, 0, 0); expect_line("s5_l1", 0);
      tag = 2;
      drive_line(2, 1, 0, 0); expect_line("s5_l2", 6);
      tag = -1;
      gap = 0;

      for (int i = 0; i < 20; i++) begin
         check($sformatf("tbl%0d_tag%0d_wx%0d_e%0d", i, tbl[i].tag, tbl[i].wx, tbl[i].idx),
               72'(snap[tbl[i].tag][tbl[i].wx][tbl[i].idx*8 +: 8]), 72'(tbl[i].exp));
         $display("vec %0d tag=%0d wx=%0d elem=%0d exp=%h", i, tbl[i].tag, tbl[i].wx, tbl[i].idx, tbl[i].exp);
      end

`ifdef VGA_CONV_WINDOW_STATS_EN
      drive_sof();
      for (int l = 0; l < 5; l++) drive_line(l, 0, 0, 0);
      drive_sof();
      check("s6_frame_windows", 72'(frame_windows), 72'(18));
`endif

      // Randomized frames: random data, tick gaps, blanking and bad x_pos.
      rnd_gap = 1;
      for (int f = 0; f < 3; f++) begin
         drive_sof();
         for (int l = 0; l < 5; l++) drive_line(l, 0, 1, 0);
      end
      rnd_gap = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_conv_window.md
Name: vga_conv_window

Overview:
- Downstream consumer of the horizontal timing stage (pixel_tick, hvideo_on, x_pos, eol) and of the vertical start-of-frame pulse.
- Buffers the two previous active lines in on-chip line RAMs.
- Combines them with the incoming pixel stream into a registered 3x3 pixel window for the convolution core.
- Emits window_valid only where a full 3x3 neighbourhood exists, so there is no border output.

Parameters:
- DATA_W, 8, pixel width in bits
- LINE_W, 640, active pixels per line; also the line RAM depth
- X_W, 10, width of x_pos and win_x

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_tick  in  1  pixel-rate enable; all state advances only on clk edges with pixel_tick=1
- hvideo_on  in  1  horizontal active-video flag, aligned with x_pos
- x_pos  in  X_W  current active column, 0..LINE_W-1
- eol  in  1  end-of-line pulse, one pixel_tick wide
- sof  in  1  start-of-frame pulse from vertical timing, one pixel_tick wide
- pixel_in  in  DATA_W  pixel for (x_pos, current row), valid when hvideo_on=1
- window  out  9*DATA_W  3x3 window; element r*3+c at bits [(r*3+c)*DATA_W +: DATA_W]; r0 = oldest row, c0 = leftmost column
- window_valid  out  1  window holds a complete neighbourhood
- win_x  out  X_W  column of the window centre (x_pos-1 of the producing pixel)

Behaviour:
- Reset, asynchronous, active-high:
  - window=0, window_valid=0, win_x=0.
  - rows_filled=0, col_cnt=0, column shift registers=0.
  - Line RAM contents are not cleared.
- Accept condition: accept = pixel_tick && hvideo_on && (x_pos < LINE_W). When x_pos >= LINE_W the pixel is ignored: no RAM write, window_valid=0 on that tick.
- On accept:
  - Read lb1[x_pos] (top) and lb0[x_pos] (mid).
  - Write lb0[x_pos] <= pixel_in and lb1[x_pos] <= old lb0[x_pos] (read-before-write, same address).
  - Build column {top, mid, pixel_in}; shift columns c0 <= c1 <= c2 <= new column.
- RAM reads are combinational or first-word-fall-through so that output latency is exactly 1 accepted tick.
- col_cnt:
  - Increments on each accept, saturating at 3.
  - Cleared on eol and on sof.
- rows_filled:
  - Increments on eol when the finishing line had at least 1 accept; saturates at 2.
  - Cleared on sof.
  - sof and eol on the same tick: sof wins; rows_filled=0 and col_cnt=0.
- Outputs are registered and update only on pixel_tick edges:
  - window_valid <= accept && rows_filled==2 && col_cnt>=2, where col_cnt is the value before this accept.
  - window and win_x <= x_pos-1 load whenever window_valid loads 1.
  - When window_valid loads 0, window and win_x hold their last value.
- Per-line output shape:
  - First valid centre of each line is win_x=1; last is win_x=LINE_W-2.
  - LINE_W-2 valid windows per line, from the third active line of a frame onward.
- pixel_tick=0: all state holds, including window_valid (it is a level sampled with pixel_tick).
- hvideo_on=0 with pixel_tick=1: window_valid <= 0; the column registers hold.
- Reset mid-frame: the next window_valid requires a fresh sof-free fill of 2 lines plus 2 pixels; stale RAM data is never flagged valid.

Optional Feature:
- Macro: VGA_CONV_WINDOW_STATS_EN.
- Defined:
  - Adds output port frame_windows [19:0], counting window_valid assertions (at pixel_tick) in the current frame.
  - On sof the count is copied to frame_windows and the internal counter is cleared; the copy is cleared on reset.
  - The counter saturates at 2^20-1.
- Undefined: no port and no counter; all other behaviour is identical.

Test Plan:
- Config for all scenarios: DATA_W=8, LINE_W=8, pixel_tick every cycle, pixel_in={row[3:0],col[3:0]}.
- 1. sof, then 3 lines of 8 active pixels -> window_valid=0 through lines 0-1. Line 2 gives 6 valid ticks with win_x=1..6. At win_x=1: window[0..8]=0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
- 2. Continue to line 3 -> centre row 2; at win_x=6: window[0]=0x15, window[8]=0x37.
- 3. Assert reset at line 3, pixel 4 -> outputs 0 immediately (asynchronous). After release with no sof, 2 further lines give no valid window; the third gives valid again.
- 4. sof and eol on the same tick after line 4 -> rows_filled=0; the next 2 lines produce window_valid=0.
- 5. pixel_tick pulsed every 4th cycle, with x_pos=9 injected -> window values match scenario 1 at 1/4 rate; x_pos=9 causes no write and window_valid=0.
- 6. (STATS_EN) 5 lines of 8 pixels, then sof -> frame_windows=18.
